uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in the rx_i synchroniser (legal range 2..4).
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port div_i  input  11  baud divisor; one oversample tick every div_i+1 clocks, 16 ticks per bit.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_o  output  8  last correctly framed byte received.
REQ-007 SHALL have port rx_valid_o  output  1  one-cycle pulse when data_o has been updated.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port rx_busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass rx_i through SYNC_STAGES flip-flops before any use; the FSM sees only the synchronised value (rx_s).
REQ-011 SHALL frame data as 1 start (0), 8 data bits LSB first, 1 stop (1), matching uart_tx at the same div_i.
REQ-012 SHALL latch div_i on start detection; changes to div_i mid-frame SHALL have no effect until the next frame.
REQ-013 SHALL use an 11-bit baud counter counting 0..div_latched, raising a tick when it equals div_latched and then wrapping to 0; div_i = 0 gives a tick every clock.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; 4-bit tick counter s_cnt, 3-bit bit counter n_cnt.
REQ-015 IDLE: on a falling edge of rx_s (previous 1, current 0), go to START and clear the baud counter, s_cnt and n_cnt; a level low without a preceding high SHALL NOT start a frame.
REQ-016 START: on each tick increment s_cnt; on the tick where s_cnt = 7, go to DATA with s_cnt cleared if rx_s = 0, else go to IDLE as a false start with no output pulse.
REQ-017 DATA: on each tick increment s_cnt; on the tick where s_cnt = 15, shift rx_s into bit 7 of the shift register (right shift), clear s_cnt, and increment n_cnt; after the bit with n_cnt = 7 go to STOP.
REQ-018 STOP: on the tick where s_cnt = 15, sample rx_s and go to IDLE; if 1, load data_o from the shift register and pulse rx_valid_o; if 0, pulse frame_err_o and leave data_o unchanged.
REQ-019 rx_valid_o and frame_err_o SHALL be registered, each high for exactly one clock per frame, and never high together.
REQ-020 Latency: rx_valid_o SHALL assert 152*(div_i+1) + SYNC_STAGES + 1 clocks (±2) after the falling edge of rx_i.
REQ-021 A new falling edge SHALL be accepted from the first IDLE cycle after STOP; back-to-back frames with no idle gap SHALL be received without loss.
REQ-022 Break or stuck-low line: after frame_err_o, no further frame SHALL start until rx_s has been seen high (edge rule, REQ-015).

Reset
REQ-023 While rst_ni = 0 at a clock edge: FSM enters IDLE; all counters are 0; synchroniser flops and the edge-detect register are set to 1; data_o = 8'h00; rx_valid_o = 0; frame_err_o = 0; rx_busy_o = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid_o or frame_err_o pulse; the partial byte SHALL NOT appear on data_o.

Verification
REQ-025 Loopback: uart_tx with div_i = 16 sends 8'hA5 -> exactly one rx_valid_o pulse, data_o = 8'hA5, no frame_err_o, timing per REQ-020.
REQ-026 Back-to-back: 64 random bytes via uart_tx with tx_start held, div_i = 16 and div_i = 0 -> 64 matching bytes in order, zero frame_err_o.
REQ-027 Glitch: rx_i low for 5*(div_i+1) clocks, then high -> no pulses, rx_busy_o falls within 9*(div_i+1) clocks, next valid frame received correctly.
REQ-028 Framing: after a good 8'h3C, drive a frame of 8'hFF with stop bit 0 -> one frame_err_o pulse, no rx_valid_o, data_o stays 8'h3C.
REQ-029 Break: hold rx_i low for 30 bit periods, then high, then send 8'h5A -> exactly one frame_err_o during the break, then rx_valid_o with data_o = 8'h5A.
REQ-030 Reset mid-frame: assert rst_ni = 0 for 2 clocks during data bit 4 of 8'hC3 -> all outputs at reset values, no pulse, next frame 8'h81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x oversampling baud timer.
// The start bit is sampled mid-bit, data bits are sampled every 16 ticks after that, and the line is synchronised into clk_i first.
//
// state | meaning
// IDLE  | waiting for a 1->0 transition on the synchronised line
// START | counting to mid start bit, confirming the line is still low
// DATA  | sampling 8 data bits, LSB first, one every 16 ticks
// STOP  | sampling the stop bit, then publishing the byte or flagging an error
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [10:0] div_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        rx_valid_o,
  output logic        frame_err_o,
  output logic        rx_busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic [10:0]            div_q;
  logic [10:0]            baud_cnt;
  logic [3:0]             s_cnt;
  logic [2:0]             n_cnt;
  logic [7:0]             shift_q;
  logic                   tick;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign tick      = (state != IDLE) && (baud_cnt == div_q);
  assign rx_busy_o = (state != IDLE);

  // Synchroniser resets to the idle-high level so that reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      div_q       <= '0;
      baud_cnt    <= '0;
      s_cnt       <= '0;
      n_cnt       <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= tick ? 11'd0 : baud_cnt + 11'd1;
      end
      case (state)
        IDLE: begin
          // A low line without a preceding high (e.g. a break) never starts a frame.
          if (rx_prev && !rx_s) begin
            state    <= START;
            div_q    <= div_i;
            baud_cnt <= '0;
            s_cnt    <= '0;
            n_cnt    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == 4'd7) begin
              s_cnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              shift_q <= {rx_s, shift_q[7:1]};
              s_cnt   <= '0;
              n_cnt   <= n_cnt + 3'd1;
              if (n_cnt == 3'd7) begin
                state <= STOP;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == 4'd15) begin
              state <= IDLE;
              s_cnt <= '0;
              if (rx_s) begin
                data_o     <= shift_q;
                rx_valid_o <= 1'b1;
              end else begin
                frame_err_o <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
